// File: rtl/rhs_spi_responder_pkg.sv
// Shared constants and FSM state type for the RHS2116-style SPI responder.
package rhs_pkg;

    localparam int FRAME_BITS = 32;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_CLEAR   = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [15:0] WRITE_PREFIX = 16'hFFFF;
    localparam logic [15:0] READ_PREFIX  = 16'h0000;
    localparam logic [7:0]  CHIP_ID_ADDR = 8'd255;

    typedef enum logic [1:0] {
        ST_ARMED_WAIT,
        ST_IDLE,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/rhs_spi_responder_sync.sv
// Multi-flop synchronizer for SCLK/MOSI/CS with rise/fall pulses on SCLK and CS.
module rhs_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic mosi_in,
    input  logic cs_in,
    output logic mosi,
    output logic cs,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sclk_p0;
    logic [SYNC_STAGES-1:0] mosi_p0;
    logic [SYNC_STAGES-1:0] cs_p0;
    logic                   sclk_p1;
    logic                   cs_p1;

    // CS resets low so a frame already in flight at reset never produces a false falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_p0 <= '0;
            mosi_p0 <= '0;
            cs_p0   <= '0;
            sclk_p1 <= 1'b0;
            cs_p1   <= 1'b0;
        end else begin
            sclk_p0 <= {sclk_p0[SYNC_STAGES-2:0], sclk_in};
            mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], mosi_in};
            cs_p0   <= {cs_p0[SYNC_STAGES-2:0], cs_in};
            sclk_p1 <= sclk_p0[SYNC_STAGES-1];
            cs_p1   <= cs_p0[SYNC_STAGES-1];
        end
    end

    assign mosi      = mosi_p0[SYNC_STAGES-1];
    assign cs        = cs_p0[SYNC_STAGES-1];
    assign sclk_rise =  sclk_p0[SYNC_STAGES-1] & ~sclk_p1;
    assign sclk_fall = ~sclk_p0[SYNC_STAGES-1] &  sclk_p1;
    assign cs_rise   =  cs_p0[SYNC_STAGES-1] & ~cs_p1;
    assign cs_fall   = ~cs_p0[SYNC_STAGES-1] &  cs_p1;

endmodule

// File: rtl/rhs_spi_responder.sv
// Oversampled SPI responder emulating RHS2116 command/response timing (responses lag two frames).
// Optional sticky framing-error flag enabled by defining RHS_SPI_RESP_FRAME_ERR_EN.
module rhs_spi_responder
    import rhs_pkg::*;
#(
    parameter int          REG_COUNT   = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] CHIP_ID     = 16'h0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [31:0] cmd_word,
    output logic        frame_err
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic mosi_s, cs_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

    rhs_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (SCLK),
        .mosi_in   (MOSI),
        .cs_in     (CS),
        .mosi      (mosi_s),
        .cs        (cs_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall)
    );

    state_t state, state_nx;

    logic [5:0]  bit_cnt;
    logic [31:0] rx_sr, tx_sr, tx_word, pending, resp;
    logic [9:0]  frame_cnt;
    logic [15:0] regs [REG_COUNT];

    logic [7:0]    addr;
    logic [AW-1:0] idx;
    logic          in_range, accept;

    assign addr     = rx_sr[23:16];
    assign idx      = addr[AW-1:0];
    assign in_range = int'(addr) < REG_COUNT;
    assign accept   = (state == ST_SHIFT) && cs_rise && (bit_cnt == 6'(FRAME_BITS));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ARMED_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_ARMED_WAIT: if (cs_s)    state_nx = ST_IDLE;
            ST_IDLE:       if (cs_fall) state_nx = ST_SHIFT;
            ST_SHIFT:      if (cs_rise) state_nx = ST_IDLE;
            default:                    state_nx = ST_ARMED_WAIT;
        endcase
    end

    always_comb begin
        resp = '0;
        case (rx_sr[31:30])
            OP_CONVERT: resp = {10'b0, rx_sr[21:16], 6'b0, frame_cnt};
            OP_WRITE:   resp = {WRITE_PREFIX, rx_sr[15:0]};
            OP_READ: begin
                if (addr == CHIP_ID_ADDR) resp = {READ_PREFIX, CHIP_ID};
                else if (in_range)        resp = {READ_PREFIX, regs[idx]};
                else                      resp = {READ_PREFIX, 16'h0000};
            end
            default:    resp = '0;
        endcase
    end

    // MSB of the transmit shifter is the live MISO bit; it is loaded at CS fall and shifted on SCLK fall.
    assign MISO = (state == ST_SHIFT) ? tx_sr[31] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_word  <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            tx_word   <= '0;
            pending   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (state == ST_IDLE && cs_fall) begin
                bit_cnt <= '0;
                tx_sr   <= tx_word;
            end else if (state == ST_SHIFT && !cs_rise) begin
                if (sclk_rise && bit_cnt < 6'(FRAME_BITS)) begin
                    rx_sr   <= {rx_sr[30:0], mosi_s};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                if (sclk_fall) tx_sr <= {tx_sr[30:0], 1'b0};
            end
            if (accept) begin
                cmd_valid <= 1'b1;
                cmd_word  <= rx_sr;
                tx_word   <= pending;
                pending   <= resp;
                if (rx_sr[31:30] == OP_CONVERT)           frame_cnt <= frame_cnt + 10'd1;
                if (rx_sr[31:30] == OP_WRITE && in_range) regs[idx] <= rx_sr[15:0];
            end
        end
    end

`ifdef RHS_SPI_RESP_FRAME_ERR_EN
    // Short frames and a 33rd SCLK rise both latch the flag until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if ((cs_rise && bit_cnt != 6'(FRAME_BITS)) ||
                (!cs_rise && sclk_rise && bit_cnt == 6'(FRAME_BITS)))
                frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rhs_spi_responder.sv
// Directed bench: bit-banged SPI master with hand-computed two-frame-delayed responses.
module tb_rhs_spi_responder;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        CS = 1'b1;
    wire         MISO;
    wire         cmd_valid;
    wire  [31:0] cmd_word;
    wire         frame_err;

    int vecs = 0;
    int errs = 0;
    int nvalid = 0;

    rhs_spi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .CS        (CS),
        .MISO      (MISO),
        .cmd_valid (cmd_valid),
        .cmd_word  (cmd_word),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_valid === 1'b1) nvalid++;

    // One SPI frame of nbits; rst is pulsed just before bit rst_bit when rst_bit >= 0.
    task automatic xfer(input logic [31:0] tx, input int nbits, input int rst_bit,
                        output logic [31:0] rx);
        rx   = '0;
        MOSI = tx[31];
        CS   = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                @(posedge clk); #1 rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
            SCLK = 1'b1;
            rx   = {rx[30:0], MISO};
            #HALF;
            SCLK = 1'b0;
            if (i < 31) MOSI = tx[30-i];
            #HALF;
        end
        CS   = 1'b1;
        MOSI = 1'b0;
        #(HALF*4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vecs++; if (MISO !== 1'b0)      begin errs++; $display("FAIL reset_miso got %b want 0", MISO); end
        vecs++; if (cmd_valid !== 1'b0) begin errs++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        vecs++; if (cmd_word !== 32'h0) begin errs++; $display("FAIL reset_cmd_word got %h want 00000000", cmd_word); end
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_write_read;
        logic [31:0] cmd [4];
        logic [31:0] exp [4];
        logic [31:0] rx;
        int n0;
        cmd = '{32'h8005_BEEF, 32'hC005_0000, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'hFFFF_BEEF, 32'h0000_BEEF};
        n0 = nvalid;
        for (int i = 0; i < 4; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL write_read[%0d] got %h want %h", i, rx, exp[i]); end
        end
        vecs++; if (cmd_word !== 32'h4000_0000) begin errs++; $display("FAIL write_read_cmd_word got %h want 40000000", cmd_word); end
        vecs++; if (nvalid - n0 !== 4) begin errs++; $display("FAIL write_read_valid_count got %0d want 4", nvalid - n0); end
    endtask

    task automatic test_convert;
        logic [31:0] cmd [5];
        logic [31:0] exp [5];
        logic [31:0] rx;
        cmd = '{32'h0011_0000, 32'h0011_0000, 32'h0011_0000, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'h0011_0000, 32'h0011_0001, 32'h0011_0002};
        for (int i = 0; i < 5; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL convert[%0d] got %h want %h", i, rx, exp[i]); end
        end
    endtask

    task automatic test_chip_id;
        logic [31:0] cmd [3];
        logic [31:0] exp [3];
        logic [31:0] rx;
        cmd = '{32'hC0FF_0000, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'h0000_0020};
        for (int i = 0; i < 3; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL chip_id[%0d] got %h want %h", i, rx, exp[i]); end
        end
    endtask

    task automatic test_truncated;
        logic [31:0] cmd [4];
        logic [31:0] exp [4];
        logic [31:0] rx;
        logic        err_exp;
        int n0;
`ifdef RHS_SPI_RESP_FRAME_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        cmd = '{32'h8001_1111, 32'h8002_2222, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'hFFFF_1111, 32'hFFFF_2222};
        n0 = nvalid;
        for (int i = 0; i < 4; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL truncated_seq[%0d] got %h want %h", i, rx, exp[i]); end
            if (i == 0) xfer(32'h8003_3333, 20, -1, rx);
        end
        vecs++; if (nvalid - n0 !== 4) begin errs++; $display("FAIL truncated_valid_count got %0d want 4", nvalid - n0); end
        vecs++; if (frame_err !== err_exp) begin errs++; $display("FAIL truncated_frame_err got %b want %b", frame_err, err_exp); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] cmd [3];
        logic [31:0] exp [3];
        logic [31:0] rx;
        int n0;
        xfer(32'h8000_1234, 32, -1, rx);
        n0 = nvalid;
        xfer(32'hC000_0000, 32, 12, rx);
        vecs++; if (nvalid - n0 !== 0) begin errs++; $display("FAIL reset_mid_valid_count got %0d want 0", nvalid - n0); end
        cmd = '{32'hC000_0000, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL reset_mid_seq[%0d] got %h want %h", i, rx, exp[i]); end
        end
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_mid_frame_err got %b want 0", frame_err); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] cmd [4];
        logic [31:0] exp [4];
        logic [31:0] rx;
        cmd = '{32'h8028_ABCD, 32'hC028_0000, 32'h4000_0000, 32'h4000_0000};
        exp = '{32'h0, 32'h0, 32'hFFFF_ABCD, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            xfer(cmd[i], 32, -1, rx);
            vecs++;
            if (rx !== exp[i]) begin errs++; $display("FAIL out_of_range[%0d] got %h want %h", i, rx, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_convert();
        test_chip_id();
        test_truncated();
        test_reset_mid_frame();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
